mem_access_unit: RTL

Sequencer that sits directly upstream of the 16x16 synchronous data memory controller. It turns one load/store request (LW, SW, LM, SM) from the execute stage into per-word memory cycles and register-file reads and writes.

---
 rtl/mem_access_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the 16x16 synchronous data memory: expands LW/SW/LM/SM into per-word memory cycles and register-file transfers.
// Optional out-of-range suppression is compiled in with `define MAU_RANGE_CHECK_EN.
module mem_access_unit #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NREGS  = 8,
   parameter int unsigned REG_AW = 3,
   parameter int unsigned MEM_AW = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [DATA_W-1:0] store_data,
   input  logic [REG_AW-1:0] dest_reg,
   input  logic [NREGS-1:0]  reg_list,
   output logic              busy,
   output logic              done,
   output logic              err_oob,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rwbar,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [REG_AW-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);

`ifdef MAU_RANGE_CHECK_EN
   localparam bit RANGE_CHECK = 1'b1;
`else
   localparam bit RANGE_CHECK = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WB, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] sdata_q, sdata_d;
   logic [REG_AW-1:0] dest_q, dest_d;
   logic [NREGS-1:0]  mask_q, mask_d, mask_clr_c;
   logic              oob_q_c, oob_d_c;
   logic              busy_d, done_d, err_d, rwbar_d, rf_we_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [REG_AW-1:0] rf_raddr_d, rf_waddr_d;

   // Index of the lowest remaining register in the transfer mask.
   function automatic logic [REG_AW-1:0] low_idx(input logic [NREGS-1:0] m);
      low_idx = '0;
      for (int i = int'(NREGS) - 1; i >= 0; i--)
         if (m[i]) low_idx = REG_AW'(i);
   endfunction

   assign mask_clr_c = mask_q & (mask_q - NREGS'(1));
   assign oob_q_c    = RANGE_CHECK && ((addr_q >> MEM_AW) != '0);

   // Next-state, next-word bookkeeping and next registered outputs.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      sdata_d    = sdata_q;
      dest_d     = dest_q;
      mask_d     = mask_q;
      err_d      = err_oob;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      mem_addr_d = '0;
      rwbar_d    = 1'b1;
      rf_raddr_d = '0;
      rf_we_d    = 1'b0;
      rf_waddr_d = '0;
      oob_d_c    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               addr_d  = base_addr;
               sdata_d = store_data;
               dest_d  = dest_reg;
               mask_d  = op[1] ? reg_list : NREGS'(1);
               err_d   = 1'b0;
               state_d = (op[1] && (reg_list == '0)) ? S_DONE : S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (oob_q_c) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (!op_q[0]) begin
               state_d = S_WB;
            end else begin
               mask_d  = mask_clr_c;
               addr_d  = addr_q + ADDR_W'(1);
               state_d = (mask_clr_c == '0) ? S_DONE : S_ACCESS;
            end
         end
         S_WB: begin
            mask_d  = mask_clr_c;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = (mask_clr_c == '0) ? S_DONE : S_ACCESS;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the upcoming state so they sit in flops.
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
      oob_d_c = RANGE_CHECK && ((addr_d >> MEM_AW) != '0);
      if (state_d == S_ACCESS) begin
         mem_addr_d = addr_d;
         rwbar_d    = !(op_d[0] && !oob_d_c);
         if (op_d == 2'b11) rf_raddr_d = low_idx(mask_d);
      end
      if (state_d == S_WB) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = op_d[1] ? low_idx(mask_d) : dest_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         addr_q    <= '0;
         sdata_q   <= '0;
         dest_q    <= '0;
         mask_q    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err_oob   <= 1'b0;
         mem_addr  <= '0;
         mem_rwbar <= 1'b1;
         rf_raddr  <= '0;
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         sdata_q   <= sdata_d;
         dest_q    <= dest_d;
         mask_q    <= mask_d;
         busy      <= busy_d;
         done      <= done_d;
         err_oob   <= err_d;
         mem_addr  <= mem_addr_d;
         mem_rwbar <= rwbar_d;
         rf_raddr  <= rf_raddr_d;
         rf_we     <= rf_we_d;
         rf_waddr  <= rf_waddr_d;
      end
   end

   // Write data follows the register file combinationally for SM; read data is aligned to WB by the memory's own latency.
   assign mem_wdata = mem_rwbar ? '0 : (op_q[1] ? rf_rdata : sdata_q);
   assign rf_wdata  = rf_we ? mem_rdata : '0;

endmodule
